// File: rtl/mp3_sdi_streamer.sv
// mp3_sdi_streamer
//   Feeds MP3 bitstream bytes to the decoder's SDI port. Bytes arrive over a
//   valid/ready handshake and are shifted out MSB-first on sdi, framed by xdcs.
//   A chunk of CHUNK_BYTES bytes is opened only when the synchronised DREQ is
//   high; once open, the chunk always runs to completion.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   din        MP3 data byte
//   din_valid  din holds a valid byte
//   din_ready  byte accepted this cycle when din_valid is also high
//   dreq       decoder DREQ, asynchronous to clk
//   xdcs       decoder data chip-select, active low
//   sclk       serial clock, idle low, decoder samples on rising edge
//   sdi        serial data, MSB first
//   busy       high whenever the streamer is not idle

module mp3_sdi_streamer #(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned CHUNK_BYTES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    input  logic       dreq,
    output logic       xdcs,
    output logic       sclk,
    output logic       sdi,
    output logic       busy
);

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StGap} state_t;

    localparam logic [7:0] DivLast   = 8'(CLK_DIV - 1);
    localparam logic [7:0] ChunkLast = 8'(CHUNK_BYTES - 1);

    state_t     state_q, state_d;
    logic       dreq_meta, dreq_s;
    logic [7:0] div_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] byte_cnt;
    logic [7:0] shreg;
    logic       sclk_q;
    logic       sdi_q;
    logic       gap_phase;

    logic div_done, transfer, sclk_fall, byte_done, chunk_done, gap_done;

    always_comb begin
        div_done   = (div_cnt == DivLast);
        transfer   = din_valid && (state_q == StLoad);
        sclk_fall  = (state_q == StShift) && sclk_q && div_done;
        byte_done  = sclk_fall && (bit_cnt == 3'd7);
        chunk_done = byte_done && (byte_cnt == ChunkLast);
        // GAP spans two divider periods; gap_phase marks the second one.
        gap_done   = (state_q == StGap) && div_done && gap_phase;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (dreq_s && din_valid) state_d = StLoad;
            StLoad:  if (transfer) state_d = StShift;
            StShift: if (byte_done) state_d = chunk_done ? StGap : StLoad;
            StGap:   if (gap_done) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state; sclk and sdi come straight from flops.
    always_comb begin
        din_ready = (state_q == StLoad);
        xdcs      = !((state_q == StLoad) || (state_q == StShift));
        busy      = (state_q != StIdle);
        sclk      = sclk_q;
        sdi       = sdi_q;
    end

    // Synchroniser and serialiser datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dreq_meta <= 1'b0;
            dreq_s    <= 1'b0;
            div_cnt   <= 8'd0;
            bit_cnt   <= 3'd0;
            byte_cnt  <= 8'd0;
            shreg     <= 8'd0;
            sclk_q    <= 1'b0;
            sdi_q     <= 1'b0;
            gap_phase <= 1'b0;
        end else begin
            dreq_meta <= dreq;
            dreq_s    <= dreq_meta;
            unique case (state_q)
                StIdle: begin
                    div_cnt   <= 8'd0;
                    bit_cnt   <= 3'd0;
                    gap_phase <= 1'b0;
                    if (dreq_s && din_valid) begin
                        byte_cnt <= 8'd0;
                    end
                end
                StLoad: begin
                    div_cnt <= 8'd0;
                    sclk_q  <= 1'b0;
                    if (transfer) begin
                        shreg   <= din;
                        sdi_q   <= din[7];
                        bit_cnt <= 3'd0;
                    end
                end
                StShift: begin
                    if (div_done) begin
                        div_cnt <= 8'd0;
                        sclk_q  <= ~sclk_q;
                        if (sclk_q) begin
                            if (bit_cnt == 3'd7) begin
                                // Last fall: sdi keeps the LSB, count the byte.
                                bit_cnt  <= 3'd0;
                                byte_cnt <= chunk_done ? 8'd0 : byte_cnt + 8'd1;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                                sdi_q   <= shreg[6];
                                shreg   <= {shreg[6:0], 1'b0};
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                StGap: begin
                    sclk_q <= 1'b0;
                    if (div_done) begin
                        div_cnt   <= 8'd0;
                        gap_phase <= ~gap_phase;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mp3_sdi_streamer.sv
// Directed bench for mp3_sdi_streamer. Two instances: A (CLK_DIV=4, CHUNK_BYTES=32)
// and B (CLK_DIV=1, CHUNK_BYTES=1) share clock, reset and the byte source; only
// the instance whose dreq is raised ever opens a chunk.

module tb_mp3_sdi_streamer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = 8'd0;
    logic       din_valid = 1'b0;
    logic       dreq_a = 1'b0, dreq_b = 1'b0;
    logic       din_ready_a, xdcs_a, sclk_a, sdi_a, busy_a;
    logic       din_ready_b, xdcs_b, sclk_b, sdi_b, busy_b;

    int checks = 0;
    int failures = 0;
    int sel = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(negedge clk) cyc <= cyc + 1;

    mp3_sdi_streamer #(.CLK_DIV(4), .CHUNK_BYTES(32)) u_a (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready_a),
        .dreq(dreq_a), .xdcs(xdcs_a), .sclk(sclk_a), .sdi(sdi_a), .busy(busy_a)
    );

    mp3_sdi_streamer #(.CLK_DIV(1), .CHUNK_BYTES(1)) u_b (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready_b),
        .dreq(dreq_b), .xdcs(xdcs_b), .sclk(sclk_b), .sdi(sdi_b), .busy(busy_b)
    );

    // SPI monitors: sample sdi on each sclk rise, flag rises while xdcs is high.
    logic [7:0] sr_a, sr_b;
    logic [7:0] cap_a [128];
    logic [7:0] cap_b [128];
    int cap_n_a = 0, cap_n_b = 0, bits_a = 0, bits_b = 0;
    int viol_a = 0, viol_b = 0, rise_a = 0, rise_b = 0;
    int last_a = 0, last_b = 0, per_a = 0, per_b = 0;
    int starts_a = 0, starts_b = 0;

    always @(posedge sclk_a or posedge rst) begin
        if (rst) begin
            bits_a  <= 0;
            cap_n_a <= 0;
        end else begin
            rise_a <= rise_a + 1;
            if (xdcs_a) viol_a <= viol_a + 1;
            sr_a <= {sr_a[6:0], sdi_a};
            if (bits_a != 0) per_a <= cyc - last_a;
            last_a <= cyc;
            if (bits_a == 7) begin
                cap_a[cap_n_a & 127] <= {sr_a[6:0], sdi_a};
                cap_n_a <= cap_n_a + 1;
                bits_a  <= 0;
            end else begin
                bits_a <= bits_a + 1;
            end
        end
    end

    always @(posedge sclk_b or posedge rst) begin
        if (rst) begin
            bits_b  <= 0;
            cap_n_b <= 0;
        end else begin
            rise_b <= rise_b + 1;
            if (xdcs_b) viol_b <= viol_b + 1;
            sr_b <= {sr_b[6:0], sdi_b};
            if (bits_b != 0) per_b <= cyc - last_b;
            last_b <= cyc;
            if (bits_b == 7) begin
                cap_b[cap_n_b & 127] <= {sr_b[6:0], sdi_b};
                cap_n_b <= cap_n_b + 1;
                bits_b  <= 0;
            end else begin
                bits_b <= bits_b + 1;
            end
        end
    end

    always @(negedge xdcs_a or posedge rst) starts_a <= rst ? 0 : starts_a + 1;
    always @(negedge xdcs_b or posedge rst) starts_b <= rst ? 0 : starts_b + 1;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic cur_ready();
        return (sel != 0) ? din_ready_b : din_ready_a;
    endfunction

    function automatic logic cur_xdcs();
        return (sel != 0) ? xdcs_b : xdcs_a;
    endfunction

    function automatic int cur_caps();
        return (sel != 0) ? cap_n_b : cap_n_a;
    endfunction

    // Offer one byte and return 1 time unit after the edge that accepts it.
    task automatic send(input logic [7:0] b);
        int n = 0;
        din       = b;
        din_valid = 1'b1;
        while (!cur_ready() && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!cur_ready()) check("send_timeout", int'(cur_ready()), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_caps(input int target);
        int n = 0;
        while (cur_caps() < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Length in cycles of the next xdcs-high run.
    task automatic gap_run(output int hi);
        int n = 0;
        hi = 0;
        while (!cur_xdcs() && n < 300) begin
            @(negedge clk);
            n++;
        end
        while (cur_xdcs() && hi < 300) begin
            hi++;
            @(negedge clk);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_a"}, int'({xdcs_a, sclk_a, sdi_a, din_ready_a, busy_a}), 5'b10000);
        check({tag, "_b"}, int'({xdcs_b, sclk_b, sdi_b, din_ready_b, busy_b}), 5'b10000);
    endtask

    initial begin
        int hi, base, bad, r0, st0, n;

        // Reset state
        #1;
        check_reset_outs("rst_init");
        repeat (3) @(negedge clk);
        check_reset_outs("rst_held");

        // Full chunk, CLK_DIV=4
        rst    = 1'b0;
        dreq_a = 1'b1;
        for (int i = 0; i < 32; i++) send(8'(i));
        wait_caps(32);
        check("full_count", cap_n_a, 32);
        for (int i = 0; i < 32; i++) check($sformatf("full_byte%0d", i), int'(cap_a[i]), i);
        check("full_xdcs_viol", viol_a, 0);
        check("full_starts", starts_a, 1);
        check("full_sclk_period", per_a, 8);
        gap_run(hi);
        check("full_gap_cycles", hi, 9);
        check("full_next_start", starts_a, 2);

        // Reset, then flow control with dreq low
        @(negedge clk);
        rst       = 1'b1;
        din_valid = 1'b0;
        dreq_a    = 1'b0;
        #1;
        check_reset_outs("rst_mid");
        @(negedge clk);
        rst       = 1'b0;
        din       = 8'h40;
        din_valid = 1'b1;
        r0  = rise_a;
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (din_ready_a || !xdcs_a) bad++;
        end
        check("fc_idle_viol", bad, 0);
        check("fc_no_sclk", rise_a - r0, 0);
        dreq_a = 1'b1;
        n = 0;
        while (xdcs_a && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("fc_dreq_latency_le4", int'(n <= 4), 1);

        // dreq drops after byte 5; chunk still completes, no new chunk after
        base = cap_n_a;
        st0  = starts_a;
        for (int i = 0; i < 32; i++) begin
            send(8'(8'h40 + i));
            if (i == 5) dreq_a = 1'b0;
        end
        din = 8'h60;
        wait_caps(base + 32);
        check("drop_count", cap_n_a - base, 32);
        for (int i = 0; i < 32; i++)
            check($sformatf("drop_byte%0d", i), int'(cap_a[(base + i) & 127]), 8'h40 + i);
        repeat (300) @(negedge clk);
        check("drop_no_new_chunk", starts_a - st0, 0);
        check("drop_idle_outs", int'({xdcs_a, din_ready_a, busy_a}), 3'b100);

        // Source stall after byte 10
        dreq_a = 1'b1;
        base = cap_n_a;
        for (int i = 0; i < 32; i++) begin
            send(8'(8'h60 + i));
            if (i == 10) begin
                din_valid = 1'b0;
                bad = 0;
                repeat (100) begin
                    @(negedge clk);
                    if (xdcs_a) bad++;
                end
                check("stall_xdcs_low", bad, 0);
                check("stall_outs", int'({sclk_a, din_ready_a}), 2'b01);
            end
        end
        din_valid = 1'b0;
        wait_caps(base + 32);
        check("stall_count", cap_n_a - base, 32);
        for (int i = 0; i < 32; i++)
            check($sformatf("stall_byte%0d", i), int'(cap_a[(base + i) & 127]), 8'h60 + i);
        check("stall_xdcs_viol", viol_a, 0);

        // Reset during bit 3 of 0xA5, then 0x3C must be first on the wire
        send(8'hA5);
        din_valid = 1'b0;
        n = 0;
        while (bits_a != 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("midbyte_reached_bit3", bits_a, 3);
        rst = 1'b1;
        #1;
        check_reset_outs("rst_midbyte");
        @(negedge clk);
        rst = 1'b0;
        send(8'h3C);
        din_valid = 1'b0;
        wait_caps(1);
        check("midbyte_first", int'(cap_a[0]), 8'h3C);

        // CLK_DIV=1, CHUNK_BYTES=1 on instance B
        @(negedge clk);
        rst    = 1'b1;
        dreq_a = 1'b0;
        @(negedge clk);
        rst    = 1'b0;
        sel    = 1;
        dreq_b = 1'b1;
        for (int i = 0; i < 4; i++) send(8'(8'hC0 + i));
        wait_caps(4);
        check("b_count", cap_n_b, 4);
        for (int i = 0; i < 4; i++) check($sformatf("b_byte%0d", i), int'(cap_b[i]), 8'hC0 + i);
        check("b_starts", starts_b, 4);
        check("b_xdcs_viol", viol_b, 0);
        check("b_sclk_period", per_b, 2);
        din = 8'hD0;
        gap_run(hi);
        check("b_gap_cycles", hi, 3);
        check("a_stays_idle", starts_a, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
